// File: rtl/div_pkg.sv
// Shared definitions for the iterative leading-zero-skipping divider.
//
// Contents:
//   state_t     - divider FSM states
//   DATA_W      - datapath width
//   CNT_W       - iteration counter width (holds 1..32)
//   DIV0_QUOT   - quotient returned for division by zero
//   SIGNED_MIN  - most negative 32-bit two's-complement value
//   cond_negate - two's-complement negate when a flag is set
package div_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    localparam logic [DATA_W-1:0] DIV0_QUOT  = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] SIGNED_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Negating SIGNED_MIN wraps back to itself, which is exactly the
    // unsigned magnitude we want for that value.
    function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] value,
                                                      input logic             neg);
        cond_negate = neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/clz.sv
// Combinational 32-bit leading-zero counter.
//
// Ports:
//   value - operand
//   count - number of leading zeros; a zero operand reports 31, so callers
//           must treat zero as a special case themselves.
module clz (
    input  logic [31:0] value,
    output logic [4:0]  count
);

    // One-hot marker of the most significant set bit.
    logic [31:0] top_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_hit
            if (gi == 31) begin : g_msb
                assign top_hit[gi] = value[gi];
            end else begin : g_low
                assign top_hit[gi] = value[gi] & ~(|value[31:gi+1]);
            end
        end
    endgenerate

    // Encode the marker; with no bit set the default of 31 stands.
    always_comb begin
        count = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (top_hit[i]) begin
                count = 5'(31 - i);
            end
        end
    end

endmodule

// File: rtl/clz_div.sv
// Iterative 32-bit radix-2 restoring divider with leading-zero skipping.
// The dividend magnitude is normalised by its leading-zero count so that
// only its significant bits are iterated over.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - operand handshake (in_ready low while busy or cancel)
//   dividend, divisor     - 32-bit operands
//   is_signed             - 1: two's-complement, 0: unsigned
//   cancel                - flush: abort any operation in flight
//   out_valid / out_ready - result handshake
//   quotient, remainder   - registered results, stable while out_valid
//   busy                  - an operation is in flight
module clz_div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    input  logic        cancel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy
);

    state_t state_reg, state_next;

    logic [31:0]      a_reg, a_next;          // raw dividend
    logic [31:0]      b_reg, b_next;          // raw divisor
    logic             signed_reg, signed_next;
    logic [31:0]      dmag_reg, dmag_next;    // |divisor|
    logic [31:0]      shift_reg, shift_next;  // dividend bits out, quotient bits in
    logic [31:0]      prem_reg, prem_next;    // partial remainder
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             q_neg_reg, q_neg_next;
    logic             r_neg_reg, r_neg_next;
    logic [31:0]      quot_reg, quot_next;
    logic [31:0]      rem_reg, rem_next;

    // Operand magnitudes, meaningful while in PREP.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [4:0]  lz_count;

    assign a_neg = signed_reg & a_reg[31];
    assign b_neg = signed_reg & b_reg[31];
    assign a_mag = cond_negate(a_reg, a_neg);
    assign b_mag = cond_negate(b_reg, b_neg);

    clz u_clz (
        .value (a_mag),
        .count (lz_count)
    );

    // One restoring step: bring the next dividend bit into the partial
    // remainder and try to subtract the divisor. The 33-bit width keeps the
    // borrow visible even when the partial remainder has bit 31 set.
    logic [32:0] shifted_rem;
    logic [32:0] trial;

    assign shifted_rem = {prem_reg, shift_reg[31]};
    assign trial       = shifted_rem - {1'b0, dmag_reg};

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        signed_next = signed_reg;
        dmag_next   = dmag_reg;
        shift_next  = shift_reg;
        prem_next   = prem_reg;
        cnt_next    = cnt_reg;
        q_neg_next  = q_neg_reg;
        r_neg_next  = r_neg_reg;
        quot_next   = quot_reg;
        rem_next    = rem_reg;

        case (state_reg)
            S_IDLE: begin
                if (in_valid && !cancel) begin
                    a_next      = dividend;
                    b_next      = divisor;
                    signed_next = is_signed;
                    state_next  = S_PREP;
                end
            end

            S_PREP: begin
                q_neg_next = a_neg ^ b_neg;
                r_neg_next = a_neg;
                dmag_next  = b_mag;
                if (b_reg == 32'd0) begin
                    quot_next  = DIV0_QUOT;
                    rem_next   = a_reg;
                    state_next = S_DONE;
                end else if (signed_reg && (a_reg == SIGNED_MIN) && (b_reg == 32'hFFFF_FFFF)) begin
                    quot_next  = SIGNED_MIN;
                    rem_next   = 32'd0;
                    state_next = S_DONE;
                end else if (a_reg == 32'd0) begin
                    // Must be caught here: the counter says 31 for zero.
                    quot_next  = 32'd0;
                    rem_next   = 32'd0;
                    state_next = S_DONE;
                end else begin
                    shift_next = a_mag << lz_count;
                    prem_next  = 32'd0;
                    cnt_next   = 6'd32 - {1'b0, lz_count};
                    state_next = S_DIV;
                end
            end

            S_DIV: begin
                if (!trial[32]) begin
                    prem_next  = trial[31:0];
                    shift_next = {shift_reg[30:0], 1'b1};
                end else begin
                    // Restored value is below the divisor, so it fits in 32 bits.
                    prem_next  = shifted_rem[31:0];
                    shift_next = {shift_reg[30:0], 1'b0};
                end
                cnt_next = cnt_reg - 6'd1;
                if (cnt_reg == 6'd1) begin
                    state_next = S_FIX;
                end
            end

            S_FIX: begin
                // Once every dividend bit has shifted out, shift_reg holds
                // the unsigned quotient with zero upper bits.
                quot_next  = cond_negate(shift_reg, q_neg_reg);
                rem_next   = cond_negate(prem_reg, r_neg_reg);
                state_next = S_DONE;
            end

            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // A flush wins over everything, including loading a result.
        if (cancel && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            quot_next  = quot_reg;
            rem_next   = rem_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            signed_reg <= 1'b0;
            dmag_reg   <= '0;
            shift_reg  <= '0;
            prem_reg   <= '0;
            cnt_reg    <= '0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            quot_reg   <= '0;
            rem_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            signed_reg <= signed_next;
            dmag_reg   <= dmag_next;
            shift_reg  <= shift_next;
            prem_reg   <= prem_next;
            cnt_reg    <= cnt_next;
            q_neg_reg  <= q_neg_next;
            r_neg_reg  <= r_neg_next;
            quot_reg   <= quot_next;
            rem_reg    <= rem_next;
        end
    end

    assign in_ready  = (state_reg == S_IDLE) & ~cancel;
    assign out_valid = (state_reg == S_DONE);
    assign busy      = (state_reg != S_IDLE);
    assign quotient  = quot_reg;
    assign remainder = rem_reg;

endmodule

// File: tb/tb_clz_div.sv
// Self-checking bench for clz_div: a vector table driven through a
// scoreboard, plus hand-written cancel, backpressure and reset sequences.
module tb_clz_div;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        cancel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;

    clz_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .cancel    (cancel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Drive one operation, wait (bounded) for the result, compare against
    // the scoreboard, optionally hold out_ready low, then release it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] q, input logic [31:0] r, input int lat,
                          input int hold);
        exp_t e;
        int   cyc;
        logic [31:0] q_seen;
        logic [31:0] r_seen;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        e.q = q;
        e.r = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, lat);
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: out_valid 0 after %0d cycles, expected 1", cyc);
            void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: result 0x%08h with empty queue, expected none", quotient);
        end else begin
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            $display("op a=0x%08h b=0x%08h s=%0d -> q=0x%08h r=0x%08h lat=%0d",
                     a, b, s, quotient, remainder, cyc);
        end
        q_seen = quotient;
        r_seen = remainder;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_quotient", quotient, q_seen);
            check("hold_remainder", remainder, r_seen);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_ack", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_ack", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        //           a              b              s     q              r              lat
        vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         9};
        vecs[1]  = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  5};
        vecs[2]  = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         5};
        vecs[3]  = '{32'd5,         32'd0,         1'b0, 32'hFFFFFFFF,  32'd5,         1};
        vecs[4]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1};
        vecs[5]  = '{32'd0,         32'd3,         1'b0, 32'd0,         32'd0,         1};
        vecs[6]  = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         34};
        vecs[7]  = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000,  34};
        vecs[8]  = '{32'h80000000,  32'd2,         1'b1, 32'hC0000000,  32'd0,         34};
        vecs[9]  = '{32'd1,         32'd1,         1'b0, 32'd1,         32'd0,         3};
        vecs[10] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'd1,         32'd0,         3};
        vecs[11] = '{32'd0,         32'hFFFFFFFB,  1'b1, 32'd0,         32'd0,         1};
        vecs[12] = '{32'hFFFFFFFB,  32'd0,         1'b1, 32'hFFFFFFFF,  32'hFFFFFFFB,  1};
        vecs[13] = '{32'd12345678,  32'd1000,      1'b0, 32'd12345,     32'd678,       26};
        vecs[14] = '{32'hFFFFFF9C,  32'd7,         1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE,  9};
        vecs[15] = '{32'hFFFFFFFF,  32'h00010000,  1'b0, 32'h0000FFFF,  32'h0000FFFF,  34};
        vecs[16] = '{32'd7,         32'd9,         1'b0, 32'd0,         32'd7,         5};

        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        cancel    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].lat, 0);
        end

        // Cancel on the third DIV cycle of 1000 / 3.
        dividend  = 32'd1000;
        divisor   = 32'd3;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_cancel", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        check("cancel_in_ready_blocked", {31'd0, in_ready}, 32'd0);
        cancel = 1'b0;
        #1;
        check("cancel_in_ready_released", {31'd0, in_ready}, 32'd1);
        begin
            logic seen_valid;
            seen_valid = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen_valid = 1'b1;
            end
            check("cancel_no_out_valid", {31'd0, seen_valid}, 32'd0);
        end
        $display("cancel sequence done: busy=%0d in_ready=%0d", busy, in_ready);

        // Next operation after the flush, with 10 cycles of backpressure.
        run_op(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 6, 10);

        // Reset in the middle of an operation clears state and outputs.
        dividend  = 32'd1000;
        divisor   = 32'd3;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_quotient", quotient, 32'd0);
        check("midreset_remainder", remainder, 32'd0);
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        $display("mid-operation reset done: q=0x%08h r=0x%08h", quotient, remainder);

        // Divider still works afterwards.
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 9, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clz_div.md
# clz_div

Iterative 32-bit integer divider for the execute stage, sitting directly downstream of the combinational leading-zero counter. It instantiates that counter on the dividend magnitude, pre-normalises the dividend, and runs only as many radix-2 restoring iterations as the dividend has significant bits. It returns quotient and remainder through a valid/ready handshake to the writeback mux.

## Interface
- Parameters: none; datapath width fixed at 32.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept an operation.
- `dividend` in 32: numerator.
- `divisor` in 32: denominator.
- `is_signed` in 1: 1 = two's-complement operation, 0 = unsigned.
- `cancel` in 1: pipeline flush; abort any operation in flight.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `quotient` out 32: quotient.
- `remainder` out 32: remainder.
- `busy` out 1: an operation is in flight (state is not IDLE).

## Operation
- States are IDLE, PREP, DIV, FIX and DONE.
- **IDLE**
  - `in_ready` = 1 & ~`cancel`.
  - On `in_valid & in_ready`, latch the operands and `is_signed`, then go to PREP.
- **PREP** (one cycle)
  - Form the magnitudes `|dividend|` and `|divisor|` (negate only when signed and bit31 = 1; 0x80000000 stays 0x80000000 as unsigned).
  - Record the sign flags: quotient negative = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
  - Special cases take priority, in this order, and each loads the result and goes to DONE:
    - `divisor` = 0 → q = 0xFFFFFFFF, r = `dividend` (raw).
    - signed, `dividend` = 0x80000000 and `divisor` = 0xFFFFFFFF → q = 0x80000000, r = 0.
    - `dividend` = 0 → q = 0, r = 0. This is required because the counter reports 31, not 32, for a zero input.
  - Otherwise:
    - k = clz(`|dividend|`).
    - Shift register = `|dividend|` << k.
    - Partial remainder = 0.
    - Counter = 32 − k, in the range 1..32, 6 bits wide.
    - Go to DIV.
- **DIV** (one bit per cycle)
  - Shift {partial remainder, shift register} left by 1.
  - Trial subtract `|divisor|` using a 33-bit subtraction.
  - If non-negative, keep the difference and set the new LSB of the quotient to 1; otherwise restore and set it to 0.
  - Decrement the counter; when it reaches 1 on this edge, go to FIX.
- **FIX**
  - Apply the sign flags to quotient and remainder when `is_signed`.
  - Go to DONE.
- **DONE**
  - `out_valid` = 1; `quotient`/`remainder` are held stable.
  - On `out_ready`, go to IDLE.
- `cancel`:
  - In any state other than IDLE, go to IDLE on the next edge; the result is discarded and `out_valid` drops.
  - In IDLE it blocks acceptance that cycle.
  - It overrides `out_ready` and all special-case handling.
- Unsigned semantics for q and r: dividend = q·divisor + r, with r < divisor.
- Signed semantics: truncation toward zero, and remainder sign equals dividend sign.

## Timing
- Reset values: state IDLE, `in_ready` = 1, `out_valid` = 0, `busy` = 0, `quotient` = 0, `remainder` = 0.
- Normal latency: handshake edge E0, then `out_valid` is high after edge E0 + n + 2, where n = 32 − k.
  - Minimum is 3 cycles (dividend magnitude 1).
  - Maximum is 34 cycles (bit31 of the magnitude set).
- Special-case latency: `out_valid` is high after edge E0 + 1.
- Throughput: back-to-back operations are not overlapped. `in_ready` is low from the accept edge until the edge after `out_ready & out_valid`.
- `out_valid` stays high with stable data while `out_ready` = 0, for an unbounded time.
- Reset mid-operation behaves identically to `cancel`, and also clears the outputs to 0.
- Outputs are registered; `in_ready` depends combinationally on `cancel` only.

## Structure
- Shared package `div_pkg`:
  - State enum.
  - `DIV0_QUOT` = 32'hFFFFFFFF.
  - `SIGNED_MIN` = 32'h80000000.
  - Counter width constant = 6.
- One sub-module: the existing `clz` counter, instantiated once on the PREP magnitude.
- Negation and the 33-bit trial subtractor are inline.

## Test plan
- Unsigned 100 / 7:
  - k = 25, n = 7.
  - Expect q = 14, r = 2, with `out_valid` after edge E0 + 9.
- Signed −7 / 2:
  - Expect q = 0xFFFFFFFD, r = 0xFFFFFFFF.
- Signed 7 / −2:
  - Expect q = 0xFFFFFFFD, r = 1.
- Special cases:
  - 5 / 0 → q = 0xFFFFFFFF, r = 5.
  - Signed 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0.
  - 0 / 3 → q = 0, r = 0.
  - Each with `out_valid` after E0 + 1.
- Unsigned 0xFFFFFFFF / 1:
  - Expect q = 0xFFFFFFFF, r = 0, latency 34.
- Cancel and backpressure:
  - Assert `cancel` on the 3rd DIV cycle of 1000 / 3 → IDLE on the next edge, `out_valid` never rises.
  - Then accept 9 / 4 → q = 2, r = 1.
  - Hold `out_ready` = 0 for 10 cycles → outputs stable and `in_ready` = 0 throughout.
